// File: rtl/vga_pkg.sv
// Shared 640x480 VGA timing constants and sync-decoder state type.
// Used by the timing generator and the receive-side sync decoder.
package vga_pkg;

  localparam int H_WIDTH_DEF = 640;
  localparam int H_FP_DEF    = 16;
  localparam int H_PULSE_DEF = 96;
  localparam int H_BP_DEF    = 48;
  localparam int V_WIDTH_DEF = 480;
  localparam int V_FP_DEF    = 10;
  localparam int V_PULSE_DEF = 2;
  localparam int V_BP_DEF    = 33;

  localparam int H_TOTAL_DEF =
    H_PULSE_DEF + H_BP_DEF + H_WIDTH_DEF + H_FP_DEF;
  localparam int V_TOTAL_DEF =
    V_PULSE_DEF + V_BP_DEF + V_WIDTH_DEF + V_FP_DEF;

  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } sync_state_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vga_sync_decoder_edge.sv
// Sync polarity normalisation, sample register and edge strobe.
// Edge = input asserted now while the last enabled sample was not.
module sync_edge_detect
  import vga_pkg::*;
#(
  parameter bit POL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pix_en,
  input  logic i_sync,
  output logic o_edge
);

  logic w_asserted;
  logic r_s;

  assign w_asserted = (i_sync == POL);

  // Sample the normalised level once per pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s <= 1'b0;
    end else if (i_pix_en) begin
      r_s <= w_asserted;
    end
  end

  assign o_edge = i_pix_en & w_asserted & ~r_s;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from hsync/vsync and locks onto
// the nominal timing after a run of clean frames.
module vga_sync_decoder
  import vga_pkg::*;
#(
  parameter int H_WIDTH     = H_WIDTH_DEF,
  parameter int H_FP        = H_FP_DEF,
  parameter int H_PULSE     = H_PULSE_DEF,
  parameter int H_BP        = H_BP_DEF,
  parameter int V_WIDTH     = V_WIDTH_DEF,
  parameter int V_FP        = V_FP_DEF,
  parameter int V_PULSE     = V_PULSE_DEF,
  parameter int V_BP        = V_BP_DEF,
  parameter int H_POL       = 0,
  parameter int V_POL       = 0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  input  logic             hsync_in,
  input  logic             vsync_in,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             active,
  output logic             frame_start,
  output logic             locked,
  output logic             err_h,
  output logic             err_v
);

  localparam int H_TOTAL = H_PULSE + H_BP + H_WIDTH + H_FP;
  localparam int V_TOTAL = V_PULSE + V_BP + V_WIDTH + V_FP;

  localparam logic [CNT_W-1:0] L_H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] L_V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] L_H_ACT0 = CNT_W'(H_PULSE + H_BP);
  localparam logic [CNT_W-1:0] L_H_ACT1 =
    CNT_W'(H_PULSE + H_BP + H_WIDTH - 1);
  localparam logic [CNT_W-1:0] L_V_ACT0 = CNT_W'(V_PULSE + V_BP);
  localparam logic [CNT_W-1:0] L_V_ACT1 =
    CNT_W'(V_PULSE + V_BP + V_WIDTH - 1);
  localparam logic [2:0]       L_LOCK   = 3'(LOCK_FRAMES);

  logic             w_h_edge;
  logic             w_v_edge;
  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             r_h_seen;
  sync_state_t      r_state;
  sync_state_t      w_state_nxt;
  logic [2:0]       r_good;
  logic [2:0]       w_good_nxt;
  logic             r_ferr;
  logic             w_ferr_nxt;
  logic             w_err_h;
  logic             w_err_v;
  logic             w_h_in;
  logic             w_v_in;

  sync_edge_detect #(
    .POL (H_POL != 0)
  ) u_hedge (
    .clk      (clk),
    .rst      (rst),
    .i_pix_en (pix_en),
    .i_sync   (hsync_in),
    .o_edge   (w_h_edge)
  );

  sync_edge_detect #(
    .POL (V_POL != 0)
  ) u_vedge (
    .clk      (clk),
    .rst      (rst),
    .i_pix_en (pix_en),
    .i_sync   (vsync_in),
    .o_edge   (w_v_edge)
  );

  // Pixel/line counters; vsync edge wins over hsync edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt  <= '0;
      r_v_cnt  <= '0;
      r_h_seen <= 1'b0;
    end else if (pix_en) begin
      r_h_cnt <= w_h_edge ? '0 : sat_inc(r_h_cnt);
      if (w_v_edge) begin
        r_v_cnt <= '0;
      end else if (w_h_edge) begin
        r_v_cnt <= sat_inc(r_v_cnt);
      end
      if (w_h_edge) begin
        r_h_seen <= 1'b1;
      end
    end
  end

  // The first hsync edge has no previous line to measure.
  assign w_err_h = !rst && w_h_edge && r_h_seen &&
                   (r_h_cnt != L_H_LAST);
  assign w_err_v = !rst && w_v_edge && (r_state != SEARCH) &&
                   ((r_v_cnt != L_V_LAST) || !w_h_edge);

  // Lock state, clean-frame count and current-frame error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEARCH;
      r_good  <= '0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_good  <= w_good_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  // Errors at a vsync edge belong to the frame that just ended.
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_ferr_nxt  = r_ferr | w_err_h | w_err_v;
    unique case (r_state)
      SEARCH: begin
        if (w_v_edge) begin
          w_state_nxt = MEASURE;
          w_good_nxt  = '0;
        end
      end
      MEASURE: begin
        if (w_v_edge) begin
          if (!r_ferr && !w_err_h && !w_err_v) begin
            w_good_nxt = r_good + 3'd1;
            if (r_good + 3'd1 == L_LOCK) begin
              w_state_nxt = LOCKED;
            end
          end else begin
            w_good_nxt = '0;
          end
        end else if (w_err_h) begin
          w_good_nxt = '0;
        end
      end
      LOCKED: begin
        if (w_err_h || w_err_v) begin
          w_state_nxt = MEASURE;
          w_good_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = SEARCH;
        w_good_nxt  = '0;
      end
    endcase
    if (w_v_edge) begin
      w_ferr_nxt = 1'b0;
    end
  end

  // Coordinates and qualifiers straight from counters and state.
  always_comb begin
    locked = (r_state == LOCKED);
    w_h_in = (r_h_cnt >= L_H_ACT0) && (r_h_cnt <= L_H_ACT1);
    w_v_in = (r_v_cnt >= L_V_ACT0) && (r_v_cnt <= L_V_ACT1);
    active = locked && w_h_in && w_v_in;
    x      = active ? r_h_cnt - L_H_ACT0 : '0;
    y      = active ? r_v_cnt - L_V_ACT0 : '0;
    frame_start = pix_en && !rst && active &&
                  (x == '0) && (y == '0);
    err_h  = w_err_h;
    err_v  = w_err_v;
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a shrunken 16x11 raster.
// Expected outputs come from a tick-timestamp reference model.
module tb_vga_sync_decoder;

  localparam int HW = 8, HF = 2, HPU = 3, HB = 3;
  localparam int VW = 6, VF = 1, VPU = 2, VB = 2;
  localparam int HT = HPU + HB + HW + HF;
  localparam int VT = VPU + VB + VW + VF;
  localparam int HS = HPU + HB;
  localparam int VS = VPU + VB;
  localparam bit HPOL = 1'b0;
  localparam bit VPOL = 1'b1;
  localparam int LF = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;
  logic hsync_in = 1'b1;
  logic vsync_in = 1'b0;
  logic [9:0] x, y;
  logic active, frame_start, locked, err_h, err_v;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_WIDTH (HW), .H_FP (HF), .H_PULSE (HPU), .H_BP (HB),
    .V_WIDTH (VW), .V_FP (VF), .V_PULSE (VPU), .V_BP (VB),
    .H_POL (int'(HPOL)), .V_POL (int'(VPOL)),
    .LOCK_FRAMES (LF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .x           (x),
    .y           (y),
    .active      (active),
    .frame_start (frame_start),
    .locked      (locked),
    .err_h       (err_h),
    .err_v       (err_v)
  );

  int n_tests = 0;
  int n_fail = 0;
  int n_fs, n_act, n_eh, n_ev;
  int en_mode = 0;

  // reference model: timestamps in enabled ticks
  int tk = 0;
  int h_base = 0;
  int nh = 0;
  bit ps_h = 0, ps_v = 0, hseen = 0, ferr = 0;
  int mode = 0;
  int good = 0;

  task automatic chk(input string tag, input logic [9:0] obs,
                     input logic [9:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d t=%0t",
             tag, obs, exp, $time);
    end
  endtask

  task automatic clr();
    n_fs = 0; n_act = 0; n_eh = 0; n_ev = 0;
  endtask

  task automatic model_reset();
    h_base = tk; nh = 0; ps_h = 0; ps_v = 0;
    hseen = 0; mode = 0; good = 0; ferr = 0;
  endtask

  task automatic drive(input bit hs_a, input bit vs_a);
    hsync_in = HPOL ? hs_a : !hs_a;
    vsync_in = VPOL ? vs_a : !vs_a;
  endtask

  task automatic do_reset(input bit hs_a, input bit vs_a);
    @(negedge clk);
    rst = 1'b1;
    pix_en = 1'($urandom);
    drive(hs_a, vs_a);
    @(posedge clk);
    model_reset();
    #1;
    chk("rst_x", x, 10'd0);
    chk("rst_y", y, 10'd0);
    chk("rst_active", 10'(active), 10'd0);
    chk("rst_locked", 10'(locked), 10'd0);
    chk("rst_fs", 10'(frame_start), 10'd0);
    chk("rst_err_h", 10'(err_h), 10'd0);
    chk("rst_err_v", 10'(err_v), 10'd0);
  endtask

  task automatic step(input bit hs_a, input bit vs_a, input bit en);
    int h, v;
    bit he, ve, act, eh, ev, fs;
    logic [9:0] ex, ey;
    @(negedge clk);
    rst = 1'b0;
    pix_en = en;
    drive(hs_a, vs_a);
    #1;
    h = tk - h_base;
    if (h > 1023) h = 1023;
    v = (nh > 1023) ? 1023 : nh;
    he = en && hs_a && !ps_h;
    ve = en && vs_a && !ps_v;
    act = (mode == 2) && h >= HS && h < HS + HW &&
          v >= VS && v < VS + VW;
    ex = act ? 10'(h - HS) : 10'd0;
    ey = act ? 10'(v - VS) : 10'd0;
    eh = he && hseen && (h != HT - 1);
    ev = ve && (mode != 0) && ((v != VT - 1) || !he);
    fs = en && act && h == HS && v == VS;
    chk("x", x, ex);
    chk("y", y, ey);
    chk("active", 10'(active), 10'(act));
    chk("locked", 10'(locked), 10'(mode == 2));
    chk("frame_start", 10'(frame_start), 10'(fs));
    chk("err_h", 10'(err_h), 10'(eh));
    chk("err_v", 10'(err_v), 10'(ev));
    if (en) begin
      if (frame_start) n_fs++;
      if (active) n_act++;
      if (err_h) n_eh++;
      if (err_v) n_ev++;
      if (ve) begin
        if (mode == 0) begin
          mode = 1; good = 0;
        end else if (mode == 1) begin
          if (!ferr && !eh && !ev) begin
            good++;
            if (good == LF) mode = 2;
          end else begin
            good = 0;
          end
        end else if (eh || ev) begin
          mode = 1; good = 0;
        end
        ferr = 0;
      end else if (eh && mode != 0) begin
        mode = 1; good = 0; ferr = 1;
      end
      if (he) hseen = 1;
      if (he) h_base = tk + 1;
      if (ve) nh = 0;
      else if (he) nh++;
      ps_h = hs_a;
      ps_v = vs_a;
      tk++;
    end
  endtask

  task automatic pix(input bit hs, input bit vs);
    if (en_mode == 1) begin
      step(hs, vs, 1'b0);
    end else if (en_mode == 2) begin
      while ($urandom_range(0, 3) == 0)
        step(1'($urandom), 1'($urandom), 1'b0);
    end
    step(hs, vs, 1'b1);
  endtask

  task automatic frame(input int nl, input int sl, input int slen,
                       input int voff, input int rat);
    int p, len;
    bit hs, vs;
    p = 0;
    for (int ln = 0; ln < nl; ln++) begin
      len = (ln == sl) ? slen : HT;
      for (int hp = 0; hp < len; hp++) begin
        hs = hp < HPU;
        vs = (ln < VPU) && !(ln == 0 && hp < voff);
        if (p == rat) do_reset(hs, vs);
        pix(hs, vs);
        p++;
      end
    end
  endtask

  initial begin
    int kind;
    do_reset(1'b0, 1'b0);

    // nominal timing: lock on 2nd clean vsync after SEARCH
    clr();
    frame(VT, -1, 0, 0, -1);
    frame(VT, -1, 0, 0, -1);
    #1 chk("s1_pre_lock", 10'(locked), 10'd0);
    frame(VT, -1, 0, 0, -1);
    #1 chk("s1_locked", 10'(locked), 10'd1);
    chk("s1_fs_count", 10'(n_fs), 10'd1);
    chk("s1_act_count", 10'(n_act), 10'(HW * VW));
    chk("s1_eh_count", 10'(n_eh), 10'd0);
    chk("s1_ev_count", 10'(n_ev), 10'd0);

    // one short line while locked
    clr();
    frame(VT, 5, HT - 1, 0, -1);
    #1 chk("s2_eh_count", 10'(n_eh), 10'd1);
    chk("s2_unlocked", 10'(locked), 10'd0);
    frame(VT, -1, 0, 0, -1);
    frame(VT, -1, 0, 0, -1);
    #1 chk("s2_not_yet", 10'(locked), 10'd0);
    frame(VT, -1, 0, 0, -1);
    #1 chk("s2_relocked", 10'(locked), 10'd1);
    chk("s2_ev_count", 10'(n_ev), 10'd0);

    // dropped line
    clr();
    frame(VT - 1, -1, 0, 0, -1);
    #1 chk("s3_locked_in", 10'(locked), 10'd1);
    frame(VT, -1, 0, 0, -1);
    #1 chk("s3_ev_count", 10'(n_ev), 10'd1);
    chk("s3_unlocked", 10'(locked), 10'd0);
    chk("s3_eh_count", 10'(n_eh), 10'd0);

    // vsync 3 pixels after hsync
    do_reset(1'b0, 1'b0);
    clr();
    for (int i = 0; i < 4; i++) frame(VT, -1, 0, 3, -1);
    #1 chk("s4_ev_count", 10'(n_ev), 10'd3);
    chk("s4_no_lock", 10'(locked), 10'd0);
    chk("s4_eh_count", 10'(n_eh), 10'd0);

    // relock, then reset mid active line
    for (int i = 0; i < 3; i++) frame(VT, -1, 0, 0, -1);
    #1 chk("s5_locked", 10'(locked), 10'd1);
    clr();
    frame(VT, -1, 0, 0, 5 * HT + 8);
    #1 chk("s5_eh_count", 10'(n_eh), 10'd0);
    chk("s5_ev_count", 10'(n_ev), 10'd0);
    chk("s5_unlocked", 10'(locked), 10'd0);

    // pix_en every other cycle
    en_mode = 1;
    do_reset(1'b0, 1'b0);
    clr();
    frame(VT, -1, 0, 0, -1);
    frame(VT, -1, 0, 0, -1);
    #1 chk("s6_pre_lock", 10'(locked), 10'd0);
    frame(VT, -1, 0, 0, -1);
    #1 chk("s6_locked", 10'(locked), 10'd1);
    chk("s6_fs_count", 10'(n_fs), 10'd1);
    chk("s6_act_count", 10'(n_act), 10'(HW * VW));
    chk("s6_err_count", 10'(n_eh + n_ev), 10'd0);

    // random frames and random pix_en gaps
    en_mode = 2;
    for (int i = 0; i < 14; i++) begin
      kind = $urandom_range(0, 6);
      case (kind)
        1: frame(VT, $urandom_range(1, VT - 1), HT - 1, 0, -1);
        2: frame(VT, $urandom_range(1, VT - 1), HT + 1, 0, -1);
        3: frame(VT - 1, -1, 0, 0, -1);
        4: frame(VT, -1, 0, $urandom_range(1, HT - 1), -1);
        5: frame(VT, -1, 0, 0, $urandom_range(0, HT * VT - 1));
        default: frame(VT, -1, 0, 0, -1);
      endcase
    end

    // long sync silence saturates the pixel counter
    en_mode = 0;
    for (int i = 0; i < 1030; i++) step(1'b0, 1'b0, 1'b1);
    frame(VT, -1, 0, 0, -1);
    frame(VT, -1, 0, 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA timing generator: consumes hsync/vsync and recovers pixel coordinates, an active-video qualifier and a frame-start strobe. It checks every line and frame against the nominal 640x480 timing and declares lock after consecutive clean frames. It sits on the capture/loopback path, driven by the generator's sync outputs or an external source on the same pixel clock.

## Interface
- H_WIDTH, 640, active pixels per line
- H_FP, 16, horizontal front porch
- H_PULSE, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_WIDTH, 480, active lines per frame
- V_FP, 10, vertical front porch
- V_PULSE, 2, vsync pulse width
- V_BP, 33, vertical back porch
- H_POL, 0, hsync asserted level (0 = active-low)
- V_POL, 0, vsync asserted level
- LOCK_FRAMES, 2, consecutive error-free frames required to lock (1..7)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- pix_en  in  1  pixel-rate enable; all state advances only when high
- hsync_in  in  1  horizontal sync, polarity per H_POL
- vsync_in  in  1  vertical sync, polarity per V_POL
- x  out  10  column within active area, 0 when not active
- y  out  10  row within active area, 0 when not active
- active  out  1  current pixel is in the active window and decoder is locked
- frame_start  out  1  one-cycle pulse coinciding with x=0,y=0 while locked
- locked  out  1  timing lock
- err_h  out  1  one-cycle pulse, bad line length
- err_v  out  1  one-cycle pulse, bad frame length or misaligned vsync

## Operation
- Derived: H_TOTAL = H_PULSE+H_BP+H_WIDTH+H_FP (800), V_TOTAL (525). Count 0 = first cycle of the sync pulse.
- Edges: on pix_en, s <= normalized input (asserted = 1). An edge is input asserted while s = 0.
- h_cnt: 0 on an hsync edge, else +1 per pix_en, saturating at 1023.
- v_cnt: 0 on a vsync edge, else +1 on an hsync edge, saturating at 1023. Vsync edge has priority.
- Line check, at each hsync edge after the first since reset/SEARCH entry: h_cnt != H_TOTAL-1 -> err_h.
- Frame check, at each vsync edge outside SEARCH: v_cnt != V_TOTAL-1 -> err_v. A vsync edge without an hsync edge in the same pix_en cycle -> err_v.
- FSM states:
  - SEARCH: on a vsync edge, go to MEASURE with good=0.
  - MEASURE: any error clears good. On a vsync edge in an error-free frame, good+1. When good reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED: any err_h/err_v -> MEASURE with good=0, locked drops.
- active = locked && h_cnt in [H_PULSE+H_BP, H_PULSE+H_BP+H_WIDTH-1] && v_cnt in [V_PULSE+V_BP, V_PULSE+V_BP+V_WIDTH-1].
- x = h_cnt-(H_PULSE+H_BP) and y = v_cnt-(V_PULSE+V_BP) when active, else 0. 10-bit unsigned arithmetic.

## Timing
- Reset: state SEARCH; h_cnt, v_cnt, good, s = 0; x = y = 0; active, frame_start, locked, err_h, err_v = 0.
- Reset mid-frame behaves identically to power-on reset; no error pulse is generated by reset.
- Latency: h_cnt = 0 in the cycle after the first asserted sample, i.e. one pix_en cycle behind the sync input. x/y/active are combinational from the counters and the state register.
- err_h, err_v and frame_start are high for exactly one clk, and only on pix_en cycles.
- locked rises in the clk after the qualifying vsync edge. It falls in the clk after the error.
- With pix_en low, all outputs hold, and pulses deassert.

## Structure
- Package vga_pkg holds the default timing constants, derived H_TOTAL/V_TOTAL, and the typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED}. The generator should share these constants.
- Sub-module sync_edge_detect handles polarity normalization, the sample register and edge output. It is instantiated for hsync and vsync.

## Test plan
- Drive generator-equivalent 800x525 timing with pix_en=1: locked rises after the 2nd post-SEARCH vsync edge; first locked frame gives frame_start with x=0,y=0 at h_cnt=144,v_cnt=35; active spans 640x480; no errors.
- Shorten one line to 799 while locked: err_h pulses once; locked drops; it relocks after 2 clean frames.
- Drop a line so the frame is 524: err_v pulses at the vsync edge; state returns to MEASURE.
- Assert the vsync edge 3 pixels after the hsync edge: err_v pulses; no lock.
- Assert rst mid-active-line while locked: all outputs 0 next cycle; state SEARCH; no err pulses on the first line after release.
- Toggle pix_en 1-of-2 cycles: behaviour is identical to the first scenario in pix_en-cycle terms; outputs hold on disabled cycles.
